// File: rtl/hpdc_mem_tid_remap.sv
`default_nettype none
// ============================================================================
// Module      : hpdc_mem_tid_remap
// Description : Read-channel transaction-ID remapper. Each accepted cache read
//               request is given the lowest free downstream slot ID. The cache
//               TID is stored in that slot and restored on every response beat.
//               The slot is released on the accepted last beat. Request and
//               response paths are purely combinational (zero latency).
// Revision    : 1.0 - initial release
// ============================================================================
module hpdc_mem_tid_remap #(
    parameter int UP_ID_WIDTH   = 8,
    parameter int DN_ID_WIDTH   = 3,
    parameter int REQ_PLD_WIDTH = 64,
    parameter int RSP_PLD_WIDTH = 514
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    // upstream (cache) request
    input  logic                     up_req_valid_i,
    output logic                     up_req_ready_o,
    input  logic [UP_ID_WIDTH-1:0]   up_req_id_i,
    input  logic [REQ_PLD_WIDTH-1:0] up_req_pld_i,
    // downstream (fabric) request
    output logic                     dn_req_valid_o,
    input  logic                     dn_req_ready_i,
    output logic [DN_ID_WIDTH-1:0]   dn_req_id_o,
    output logic [REQ_PLD_WIDTH-1:0] dn_req_pld_o,
    // downstream (fabric) response
    input  logic                     dn_rsp_valid_i,
    output logic                     dn_rsp_ready_o,
    input  logic [DN_ID_WIDTH-1:0]   dn_rsp_id_i,
    input  logic                     dn_rsp_last_i,
    input  logic [RSP_PLD_WIDTH-1:0] dn_rsp_pld_i,
    // upstream (cache) response
    output logic                     up_rsp_valid_o,
    input  logic                     up_rsp_ready_i,
    output logic [UP_ID_WIDTH-1:0]   up_rsp_id_o,
    output logic                     up_rsp_last_o,
    output logic [RSP_PLD_WIDTH-1:0] up_rsp_pld_o,
    // control / status
    input  logic                     block_i,
    output logic                     idle_o,
    output logic [DN_ID_WIDTH:0]     outstanding_o,
    output logic                     err_unmapped_o
);

    localparam int                     c_NSLOT   = 2 ** DN_ID_WIDTH;
    localparam logic [DN_ID_WIDTH:0]   c_CNT_MAX = (DN_ID_WIDTH + 1)'(c_NSLOT);
    localparam logic [DN_ID_WIDTH:0]   c_CNT_ONE = (DN_ID_WIDTH + 1)'(1);
    localparam logic [c_NSLOT-1:0]     c_ONE_HOT = {{(c_NSLOT - 1){1'b0}}, 1'b1};

    logic [c_NSLOT-1:0]     r_busy;
    logic [UP_ID_WIDTH-1:0] r_tid [c_NSLOT];
    logic [DN_ID_WIDTH:0]   r_cnt;
    logic                   r_err;

    logic [DN_ID_WIDTH-1:0] w_free_slot;
    logic                   w_has_free;
    logic                   w_req_open;
    logic                   w_alloc;
    logic                   w_rsp_hs;
    logic                   w_slot_busy;
    logic                   w_release;
    logic                   w_unmapped;
    logic [c_NSLOT-1:0]     w_alloc_oh;
    logic [c_NSLOT-1:0]     w_release_oh;

    // Lowest-index free slot: scan downwards so the last hit is the lowest index
    always_comb begin
        w_free_slot = '0;
        for (int i = c_NSLOT - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_slot = DN_ID_WIDTH'(i);
            end
        end
    end

    // Request path: the rstn_i term keeps the handshake closed while reset is held,
    // since the cleared table would otherwise look fully free.
    assign w_has_free     = ~&r_busy;
    assign w_req_open     = rstn_i & w_has_free & ~block_i;
    assign dn_req_valid_o = up_req_valid_i & w_req_open;
    assign up_req_ready_o = dn_req_ready_i & w_req_open;
    assign dn_req_id_o    = w_free_slot;
    assign dn_req_pld_o   = up_req_pld_i;
    assign w_alloc        = up_req_valid_i & up_req_ready_o;

    // Response path: straight pass-through with TID restored from the table
    assign up_rsp_valid_o = dn_rsp_valid_i;
    assign dn_rsp_ready_o = up_rsp_ready_i;
    assign up_rsp_id_o    = r_tid[dn_rsp_id_i];
    assign up_rsp_last_o  = dn_rsp_last_i;
    assign up_rsp_pld_o   = dn_rsp_pld_i;

    // A beat on a free slot never releases anything; it only raises the error flag.
    // Alloc targets a free slot and release a busy one, so they never collide.
    assign w_rsp_hs     = dn_rsp_valid_i & up_rsp_ready_i;
    assign w_slot_busy  = r_busy[dn_rsp_id_i];
    assign w_release    = w_rsp_hs & dn_rsp_last_i & w_slot_busy;
    assign w_unmapped   = w_rsp_hs & ~w_slot_busy;
    assign w_alloc_oh   = w_alloc   ? (c_ONE_HOT << w_free_slot) : '0;
    assign w_release_oh = w_release ? (c_ONE_HOT << dn_rsp_id_i) : '0;

    // Slot table: set busy and capture TID on alloc, clear busy on last-beat release.
    // The TID is left in place after release so late beats report the stale value.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy <= '0;
            for (int i = 0; i < c_NSLOT; i++) begin
                r_tid[i] <= '0;
            end
        end else begin
            r_busy <= (r_busy | w_alloc_oh) & ~w_release_oh;
            for (int i = 0; i < c_NSLOT; i++) begin
                if (w_alloc_oh[i]) begin
                    r_tid[i] <= up_req_id_i;
                end
            end
        end
    end

    // Outstanding counter: a simultaneous alloc and release cancel out
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (w_alloc && !w_release && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end else if (!w_alloc && w_release && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // Sticky error flag for beats that arrive on an unallocated slot
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_err <= 1'b0;
        end else if (w_unmapped) begin
            r_err <= 1'b1;
        end
    end

    assign idle_o         = ~|r_busy;
    assign outstanding_o  = r_cnt;
    assign err_unmapped_o = r_err;

endmodule
`default_nettype wire
